// File: rtl/tmr_vote_monitor.sv
// ---------------------------------------------------------------------------
// tmr_vote_monitor
//
// Registered bitwise triple-modular-redundancy vote stage with per-channel
// health tracking. The three redundant channel words are voted bit by bit.
// The voted word and the per-channel disagreement flags are registered one
// cycle after a valid sample. Each channel has a saturating counter of
// consecutive disagreements. A channel that reaches FAULT_LIMIT in a row gets
// a sticky fault flag. A saturating total counts every sample that had any
// disagreement.
//
// Optional feature macro: TMR_FAULT_IRQ_EN
//   defined     : fault_irq pulses for one cycle when any fault bit rises.
//   not defined : fault_irq is tied low and the port stays present.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, highest priority
//   in_valid   in   a/b/c carry a sample this cycle
//   a, b, c    in   [WIDTH-1:0] redundant channel words
//   clr_fault  in   clears fault flags and consecutive counters
//   out_valid  out  vote/mismatch belong to a sample this cycle
//   vote       out  [WIDTH-1:0] bitwise majority of the captured sample
//   mismatch   out  [2:0] bit0=A, bit1=B, bit2=C disagree with vote
//   fault      out  [2:0] sticky per-channel fault, same bit order
//   err_total  out  [TOTAL_W-1:0] saturating count of disagreeing samples
//   fault_irq  out  one-cycle pulse on a new fault (macro-gated)
// ---------------------------------------------------------------------------
module tmr_vote_monitor #(
   parameter int WIDTH       = 8,
   parameter int FAULT_LIMIT = 4,
   parameter int TOTAL_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   input  logic               clr_fault,
   output logic               out_valid,
   output logic [WIDTH-1:0]   vote,
   output logic [2:0]         mismatch,
   output logic [2:0]         fault,
   output logic [TOTAL_W-1:0] err_total,
   output logic               fault_irq
);

   localparam logic [3:0]         LIMIT     = 4'(FAULT_LIMIT);
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};
   localparam logic [TOTAL_W-1:0] TOTAL_ONE = {{(TOTAL_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]   vote_s;
   logic [2:0]         mis_s;
   logic [2:0][3:0]    cnt_r;
   logic [2:0][3:0]    cnt_nxt_s;
   logic [2:0]         fault_nxt_s;
   logic [TOTAL_W-1:0] err_nxt_s;
   logic               irq_nxt_s;

   // Bitwise majority of the incoming sample and per-channel disagreement.
   always_comb begin
      vote_s = (a & b) | (b & c) | (a & c);
      mis_s  = {|(c ^ vote_s), |(b ^ vote_s), |(a ^ vote_s)};
   end

   // Consecutive-disagreement counters and sticky fault flags.
   // clr_fault wins over a simultaneous sample, whose counter update is lost.
   // A fault bit only rises on the edge where its counter reaches the limit;
   // once set it simply holds, so repeated limit hits cannot re-pulse it.
   always_comb begin
      cnt_nxt_s   = cnt_r;
      fault_nxt_s = fault;
      for (int i = 0; i < 3; i++) begin
         if (clr_fault) begin
            cnt_nxt_s[i] = 4'd0;
         end else if (in_valid) begin
            if (!mis_s[i]) begin
               cnt_nxt_s[i] = 4'd0;
            end else if (cnt_r[i] >= LIMIT) begin
               cnt_nxt_s[i] = LIMIT;
            end else begin
               cnt_nxt_s[i] = cnt_r[i] + 4'd1;
            end
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end

         if (clr_fault) begin
            fault_nxt_s[i] = 1'b0;
         end else if (cnt_nxt_s[i] == LIMIT) begin
            fault_nxt_s[i] = 1'b1;
         end else begin
            fault_nxt_s[i] = fault[i];
         end
      end
   end

   // Saturating total of samples with any disagreement; rst is the only clear.
   always_comb begin
      if (in_valid && (mis_s != 3'b000) && (err_total != TOTAL_MAX)) begin
         err_nxt_s = err_total + TOTAL_ONE;
      end else begin
         err_nxt_s = err_total;
      end
   end

   // New-fault pulse: one cycle for any 0->1 transition, however many bits.
`ifdef TMR_FAULT_IRQ_EN
   always_comb begin
      irq_nxt_s = |(fault_nxt_s & ~fault);
   end
`else
   always_comb begin
      irq_nxt_s = 1'b0;
   end
`endif

   // Output and state registers; reset has priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         vote      <= {WIDTH{1'b0}};
         mismatch  <= 3'b000;
         fault     <= 3'b000;
         err_total <= {TOTAL_W{1'b0}};
         fault_irq <= 1'b0;
         cnt_r     <= {3{4'd0}};
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            vote     <= vote_s;
            mismatch <= mis_s;
         end else begin
            vote     <= vote;
            mismatch <= mismatch;
         end
         fault     <= fault_nxt_s;
         err_total <= err_nxt_s;
         fault_irq <= irq_nxt_s;
         cnt_r     <= cnt_nxt_s;
      end
   end

endmodule
